// File: rtl/gsqrt_sched_pkg.sv
// Shared types and helpers for the unary sqrt stream scheduler.
// LFSR tap masks are Fibonacci, shift-left, feedback into bit 0.
package gsqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Bit k set means stage k+1 feeds the XOR.
  function automatic logic [11:0] lfsr_taps(input int w);
    logic [11:0] m;
    case (w)
      3:       m = 12'h006;
      4:       m = 12'h00c;
      5:       m = 12'h014;
      6:       m = 12'h030;
      7:       m = 12'h060;
      8:       m = 12'h0b8;
      9:       m = 12'h110;
      10:      m = 12'h240;
      11:      m = 12'h500;
      12:      m = 12'h829;
      default: m = 12'h000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gsqrt_stream_sched_lfsr_gen.sv
// Fibonacci LFSR with synchronous seed reload and step enable.
// Seed is also the reset value, so the register is never zero.
module lfsr_gen
  import gsqrt_sched_pkg::*;
#(
  parameter int             W    = 6,
  parameter logic [W-1:0]   SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] out
);
  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/gsqrt_stream_sched.sv
// Shares one bit-serial unary sqrt core among N requesters:
// round-robin grant, core clear, LFSR streams, windowed ones count.
module gsqrt_stream_sched
  import gsqrt_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int BW      = 5,
  parameter int LEN_LOG = 8,
  parameter int WARM    = 16,
  parameter int SEED_A  = 1,
  parameter int SEED_B  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N*(BW+1)-1:0]   req_data,
  output logic [N-1:0]          req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [clog2(N)-1:0]   resp_id,
  output logic [LEN_LOG:0]      resp_data,
  output logic                  core_rst_n,
  output logic                  core_in,
  output logic [BW:0]           core_rand,
  input  logic                  core_out
);
  localparam int W    = BW + 1;
  localparam int IDW  = clog2(N);
  localparam int CW   = LEN_LOG + 1;
  localparam int RUNL = WARM + (1 << LEN_LOG);
  localparam int RW   = clog2(RUNL);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    op_q, op_d;
  logic [RW-1:0]   run_q, run_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic            crst_q, crst_d;

  logic [IDW-1:0]  gnt_idx, idx_hi, idx_lo;
  logic            hit_hi, hit_lo, any_req;
  logic [W-1:0]    gnt_op;
  logic [W-1:0]    lfsr_a, lfsr_b;
  logic            lfsr_load, lfsr_en;

  // Lowest index at/after the pointer wins, else lowest below it.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i >= int'(ptr_q)) begin
          hit_hi = 1'b1;
          idx_hi = IDW'(i);
        end else begin
          hit_lo = 1'b1;
          idx_lo = IDW'(i);
        end
      end
    end
    any_req = hit_hi | hit_lo;
    gnt_idx = hit_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    gnt_op    = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_op       = req_data[i*W +: W];
        req_ready[i] = any_req && (state_q == IDLE) && !rst;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    run_d     = run_q;
    ones_d    = ones_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d    = gnt_idx;
          op_d    = gnt_op;
          state_d = INIT;
        end
      end
      INIT: begin
        lfsr_load = 1'b1;
        run_d     = '0;
        ones_d    = '0;
        state_d   = RUN;
      end
      RUN: begin
        lfsr_en = 1'b1;
        run_d   = run_q + 1'b1;
        if (run_q >= RW'(WARM) && core_out) begin
          ones_d = ones_q + 1'b1;
        end
        if (run_q == RW'(RUNL - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so the core sees a clean clear for all non-RUN cycles.
    crst_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      run_q   <= '0;
      ones_q  <= '0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      run_q   <= run_d;
      ones_q  <= ones_d;
      crst_q  <= crst_d;
    end
  end

  lfsr_gen #(
    .W    (W),
    .SEED (W'(SEED_A))
  ) u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .en   (lfsr_en),
    .out  (lfsr_a)
  );

  lfsr_gen #(
    .W    (W),
    .SEED (W'(SEED_B))
  ) u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .en   (lfsr_en),
    .out  (lfsr_b)
  );

  assign resp_valid = (state_q == DONE);
  assign resp_id    = id_q;
  assign resp_data  = ones_q;
  assign core_rst_n = crst_q;
  assign core_in    = (state_q == RUN) && (op_q > lfsr_a);
  assign core_rand  = lfsr_b;

endmodule

// File: tb/tb_gsqrt_stream_sched.sv
// Directed bench for gsqrt_stream_sched with a behavioural sqrt core
// (saturating up/down counter, clear to mid-scale) and a golden model.
module tb_gsqrt_stream_sched;
  localparam int N = 4;
  localparam int BW = 5;
  localparam int W = 6;
  localparam int LEN_LOG = 8;
  localparam int WARM = 16;
  localparam int RUNL = 272;
  localparam int CW = 9;
  localparam int IDW = 2;
  localparam int LAT = 274;
  localparam logic [W-1:0] SA = 6'd1;
  localparam logic [W-1:0] SB = 6'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic resp_valid;
  logic resp_ready = 1'b1;
  logic [IDW-1:0] resp_id;
  logic [CW-1:0] resp_data;
  logic core_rst_n, core_in, core_out;
  logic [W-1:0] core_rand;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gsqrt_stream_sched #(
    .N(N), .BW(BW), .LEN_LOG(LEN_LOG), .WARM(WARM),
    .SEED_A(1), .SEED_B(5)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .core_rst_n(core_rst_n), .core_in(core_in),
    .core_rand(core_rand), .core_out(core_out)
  );

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction

  function automatic logic [W-1:0] core_step(
    input logic [W-1:0] c, input logic inc, input logic dec);
    if (inc && !dec && c != 6'h3f) return c + 6'd1;
    if (dec && !inc && c != 6'h00) return c - 6'd1;
    return c;
  endfunction

  // Core: output = counter > random; up on input, down on out&prev_out.
  logic [W-1:0] ccnt = 6'd32;
  logic cprev = 1'b0;
  assign core_out = (ccnt > core_rand);
  always @(posedge clk) begin
    if (!core_rst_n) begin
      ccnt <= 6'd32;
      cprev <= 1'b0;
    end else begin
      ccnt <= core_step(ccnt, core_in, core_out & cprev);
      cprev <= core_out;
    end
  end

  function automatic int golden(input logic [W-1:0] op);
    logic [W-1:0] a, b, c;
    logic p, o;
    int ones;
    a = SA; b = SB; c = 6'd32; p = 1'b0; ones = 0;
    for (int i = 0; i < RUNL; i++) begin
      o = (c > b);
      if (i >= WARM && o) ones++;
      c = core_step(c, op > a, o & p);
      p = o;
      a = lfsr_next(a);
      b = lfsr_next(b);
    end
    return ones;
  endfunction

  function automatic int exp_in_ones(input logic [W-1:0] op);
    logic [W-1:0] a;
    int n;
    a = SA; n = 0;
    for (int i = 0; i < RUNL; i++) begin
      if (op > a) n++;
      a = lfsr_next(a);
    end
    return n;
  endfunction

  // Stream monitor, sampled mid-cycle.
  logic [W-1:0] ma = SA;
  logic [W-1:0] mb = SB;
  logic [W-1:0] mop = '0;
  logic prev_rdy = 1'b0;
  int cin_err = 0, crand_err = 0, cin_ones = 0;
  int run_len = 0, last_len = 0, bad_ready = 0, bad_rstn = 0;

  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (!$onehot(req_ready) || prev_rdy || core_rst_n || resp_valid)
        bad_ready++;
      for (int i = 0; i < N; i++)
        if (req_ready[i]) mop = req_data[i*W +: W];
    end
    prev_rdy = |req_ready;
    if (core_rst_n) begin
      if (resp_valid) bad_rstn++;
      if (core_in !== (mop > ma)) cin_err++;
      if (core_rand !== mb) crand_err++;
      if (core_in) cin_ones++;
      run_len++;
      ma = lfsr_next(ma);
      mb = lfsr_next(mb);
    end else begin
      if (run_len != 0) last_len = run_len;
      run_len = 0;
      ma = SA;
      mb = SB;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int t, output logic [N-1:0] rdy,
                             output bit ok);
    ok = 1'b0; t = 0; rdy = '0;
    for (int k = 0; k < 700 && !ok; k++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1; t = cyc; rdy = req_ready;
      end else begin
        step();
      end
    end
  endtask

  task automatic wait_resp(output int t, output logic [IDW-1:0] id,
                           output logic [CW-1:0] d, output bit ok);
    ok = 1'b0; t = 0; id = '0; d = '0;
    for (int k = 0; k < 700 && !ok; k++) begin
      if (resp_valid) begin
        ok = 1'b1; t = cyc; id = resp_id; d = resp_data;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (req_ready !== 4'b0000) begin errors++;
      $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++;
      $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_id !== 2'd0 || resp_data !== 9'd0) begin errors++;
      $display("FAIL rst_resp: got id %0d data %0d want 0 0", resp_id, resp_data); end
    checks++; if (core_rst_n !== 1'b0 || core_in !== 1'b0) begin errors++;
      $display("FAIL rst_core: got rst_n %b in %b want 0 0", core_rst_n, core_in); end
    checks++; if (core_rand !== SB) begin errors++;
      $display("FAIL rst_core_rand: got %0d want %0d", core_rand, SB); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int t, tr, g;
    logic [N-1:0] rdy;
    logic [IDW-1:0] id;
    logic [CW-1:0] d;
    bit ok;
    logic [W-1:0] ops [N];
    ops[0] = 6'd10; ops[1] = 6'd20; ops[2] = 6'd30; ops[3] = 6'd45;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = ops[i];
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_accept(t, rdy, ok);
      checks++; if (!ok || rdy !== 4'(1 << k)) begin errors++;
        $display("FAIL b2b_grant%0d: got %b want %b", k, rdy, 4'(1 << k)); end
      step();
      req_valid[k] = 1'b0;
      wait_resp(tr, id, d, ok);
      g = golden(ops[k]);
      checks++; if (!ok || id !== IDW'(k)) begin errors++;
        $display("FAIL b2b_id%0d: got %0d want %0d", k, id, k); end
      checks++; if (int'(d) != g || tr - t != LAT) begin errors++;
        $display("FAIL b2b_data%0d: got %0d lat %0d want %0d lat %0d",
                 k, d, tr - t, g, LAT); end
      step();
    end
  endtask

  task automatic test_single();
    int t, tr, g, e0, r0, o0;
    logic [N-1:0] rdy;
    logic [IDW-1:0] id;
    logic [CW-1:0] d;
    bit ok;
    req_data[0 +: W] = 6'd16;
    req_valid[0] = 1'b1;
    wait_accept(t, rdy, ok);
    checks++; if (!ok || rdy !== 4'b0001) begin errors++;
      $display("FAIL single_grant: got %b want 0001", rdy); end
    e0 = cin_err; r0 = crand_err; o0 = cin_ones;
    step();
    req_valid[0] = 1'b0;
    wait_resp(tr, id, d, ok);
    checks++; if (!ok || tr - t != LAT) begin errors++;
      $display("FAIL single_latency: got %0d want %0d", tr - t, LAT); end
    checks++; if (id !== 2'd0) begin errors++;
      $display("FAIL single_id: got %0d want 0", id); end
    g = golden(6'd16);
    checks++; if (int'(d) != g) begin errors++;
      $display("FAIL single_data: got %0d want %0d", d, g); end
    checks++; if (d < 9'd96 || d > 9'd160) begin errors++;
      $display("FAIL single_range: got %0d want 96..160", d); end
    step();
    checks++; if (last_len != RUNL) begin errors++;
      $display("FAIL core_rst_n_len: got %0d want %0d", last_len, RUNL); end
    checks++; if (cin_err != e0 || crand_err != r0) begin errors++;
      $display("FAIL single_stream: got %0d/%0d bad cycles want 0",
               cin_err - e0, crand_err - r0); end
    checks++; if (cin_ones - o0 != exp_in_ones(6'd16)) begin errors++;
      $display("FAIL single_in_ones: got %0d want %0d",
               cin_ones - o0, exp_in_ones(6'd16)); end
  endtask

  task automatic test_edge_ops();
    int t, tr, g, e0, o0;
    logic [N-1:0] rdy;
    logic [IDW-1:0] id;
    logic [CW-1:0] d;
    bit ok;
    logic [W-1:0] ops [2];
    ops[0] = 6'd0; ops[1] = 6'd63;
    for (int k = 0; k < 2; k++) begin
      req_data[(k+1)*W +: W] = ops[k];
      req_valid[k+1] = 1'b1;
      wait_accept(t, rdy, ok);
      checks++; if (!ok || rdy !== 4'(2 << k)) begin errors++;
        $display("FAIL edge_grant%0d: got %b want %b", k, rdy, 4'(2 << k)); end
      e0 = cin_err; o0 = cin_ones;
      step();
      req_valid[k+1] = 1'b0;
      wait_resp(tr, id, d, ok);
      g = golden(ops[k]);
      checks++; if (!ok || int'(d) != g || id !== IDW'(k + 1)) begin errors++;
        $display("FAIL edge_data op%0d: got %0d id %0d want %0d id %0d",
                 ops[k], d, id, g, k + 1); end
      step();
      checks++; if (cin_err != e0) begin errors++;
        $display("FAIL edge_core_in op%0d: got %0d bad cycles want 0",
                 ops[k], cin_err - e0); end
      checks++; if (cin_ones - o0 != exp_in_ones(ops[k])) begin errors++;
        $display("FAIL edge_in_ones op%0d: got %0d want %0d",
                 ops[k], cin_ones - o0, exp_in_ones(ops[k])); end
    end
  endtask

  task automatic test_backpressure();
    int t, tr, g, h, bad;
    logic [N-1:0] rdy;
    logic [IDW-1:0] id, id0;
    logic [CW-1:0] d, d0;
    bit ok;
    req_data[3*W +: W] = 6'd40;
    req_data[0 +: W] = 6'd50;
    req_valid[3] = 1'b1;
    req_valid[0] = 1'b1;
    resp_ready = 1'b0;
    wait_accept(t, rdy, ok);
    checks++; if (!ok || rdy !== 4'b1000) begin errors++;
      $display("FAIL bp_grant: got %b want 1000", rdy); end
    step();
    req_valid[3] = 1'b0;
    wait_resp(tr, id0, d0, ok);
    g = golden(6'd40);
    checks++; if (!ok || id0 !== 2'd3 || int'(d0) != g) begin errors++;
      $display("FAIL bp_resp: got id %0d data %0d want id 3 data %0d", id0, d0, g); end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (resp_valid !== 1'b1 || resp_id !== id0 ||
          resp_data !== d0 || req_ready !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    resp_ready = 1'b1;
    h = cyc;
    wait_accept(t, rdy, ok);
    checks++; if (!ok || t != h + 1 || rdy !== 4'b0001) begin errors++;
      $display("FAIL bp_next_accept: got cycle %0d grant %b want %0d 0001",
               t, rdy, h + 1); end
    step();
    req_valid[0] = 1'b0;
    wait_resp(tr, id, d, ok);
    g = golden(6'd50);
    checks++; if (!ok || id !== 2'd0 || int'(d) != g) begin errors++;
      $display("FAIL bp_after: got id %0d data %0d want id 0 data %0d", id, d, g); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int t, tr, g, n, rc, spur;
    logic [N-1:0] rdy;
    logic [IDW-1:0] id;
    logic [CW-1:0] d;
    bit ok;
    req_data[1*W +: W] = 6'd30;
    req_valid[1] = 1'b1;
    wait_accept(t, rdy, ok);
    checks++; if (!ok || rdy !== 4'b0010) begin errors++;
      $display("FAIL mid_grant: got %b want 0010", rdy); end
    step();
    req_valid[1] = 1'b0;
    n = 0;
    while (run_len < 100 && n < 400) begin
      step();
      n++;
    end
    checks++; if (run_len != 100) begin errors++;
      $display("FAIL mid_run_reach: got %0d want 100", run_len); end
    req_data[2*W +: W] = 6'd45;
    req_valid[2] = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0 ||
                  resp_id !== 2'd0 || resp_data !== 9'd0) begin errors++;
      $display("FAIL mid_rst_resp: got rdy %b v %b id %0d d %0d want 0000 0 0 0",
               req_ready, resp_valid, resp_id, resp_data); end
    checks++; if (core_rst_n !== 1'b0 || core_in !== 1'b0 ||
                  core_rand !== SB) begin errors++;
      $display("FAIL mid_rst_core: got %b %b %0d want 0 0 %0d",
               core_rst_n, core_in, core_rand, SB); end
    repeat (3) step();
    rst = 1'b0;
    rc = cyc;
    wait_accept(t, rdy, ok);
    checks++; if (!ok || t != rc || rdy !== 4'b0100) begin errors++;
      $display("FAIL mid_after_grant: got cycle %0d %b want %0d 0100", t, rdy, rc); end
    step();
    req_valid[2] = 1'b0;
    spur = 0;
    wait_resp(tr, id, d, ok);
    if (tr - t != LAT) spur = 1;
    g = golden(6'd45);
    checks++; if (!ok || spur != 0 || id !== 2'd2 || int'(d) != g) begin errors++;
      $display("FAIL mid_after_resp: got id %0d data %0d lat %0d want 2 %0d %0d",
               id, d, tr - t, g, LAT); end
    step();
  endtask

  task automatic test_invariants();
    checks++; if (bad_ready != 0) begin errors++;
      $display("FAIL ready_pulse: got %0d bad pulses want 0", bad_ready); end
    checks++; if (bad_rstn != 0) begin errors++;
      $display("FAIL rst_n_in_done: got %0d want 0", bad_rstn); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_edge_ops();
    test_backpressure();
    test_reset_mid_run();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gsqrt_stream_sched.md
Name: gsqrt_stream_sched

Overview:
- Time-multiplexes one shared unary square-root core (bit-serial, BW-parameterised, internal up/down counter state) among N requesters.
- Arbitrates each binary operand request round-robin, then re-initialises the core.
- Generates the input bitstream and the core's comparison random number from two LFSRs, counts output ones over a fixed stream window, and returns the binary result with the requester ID.

Parameters:
- N, 4, number of requesters (2..16).
- BW, 5, core width parameter; operand and random-number width is W=BW+1.
- LEN_LOG, 8, log2 of counted stream length (L=2^LEN_LOG cycles).
- WARM, 16, warm-up cycles run before counting starts (0..255).
- SEED_A, 1, input-LFSR seed (non-zero, W bits).
- SEED_B, 5, core-random LFSR seed (non-zero, W bits, != SEED_A).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  N  per-requester operand valid.
- req_data  in  N*W  operands, requester i at bits [i*W +: W].
- req_ready  out  N  one-hot accept pulse.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumer ready.
- resp_id  out  clog2(N)  requester index of the result.
- resp_data  out  LEN_LOG+1  count of core output ones over L cycles.
- core_rst_n  out  1  registered active-low clear to the core (flop output, glitch-free).
- core_in  out  1  unary input bit to the core.
- core_rand  out  W  random number to the core comparator.
- core_out  in  1  core output bit (combinational from core state).

Behaviour:
- Reset: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_data=0, core_rst_n=0, core_in=0, core_rand=SEED_B, RR pointer=0, LFSRs at seeds.
- Reset mid-job aborts the job; no response is produced. Reset is asynchronous on assertion and takes effect on the next clk edge after deassertion.
- FSM states and transitions:
  - IDLE: if any req_valid, grant the first asserted index at or after the pointer (wrapping). In that same cycle, req_ready[g]=1, latch req_data[g] and g, go INIT. core_rst_n=0 throughout IDLE.
  - INIT: exactly 1 cycle. core_rst_n=0, both LFSRs reloaded to seeds, run counter and ones counter cleared. Go RUN.
  - RUN: core_rst_n=1 for WARM+L cycles.
    - core_in = (operand > lfsr_a) each cycle.
    - core_rand = lfsr_b.
    - Both LFSRs advance every RUN cycle.
    - core_out is sampled each cycle; the ones counter increments when run index >= WARM.
    - After the last cycle, go DONE.
  - DONE: resp_valid=1; resp_id and resp_data stable. On resp_valid&resp_ready, go IDLE and set pointer=(id+1) mod N. core_rst_n returns to 0.
- Latency: accept at cycle T, INIT at T+1, RUN T+2..T+1+WARM+L, resp_valid first high at T+2+WARM+L (T+274 with defaults). Next grant no earlier than the cycle after the response handshake.
- LFSRs: Fibonacci, maximal-length polynomial for W taken from the package table. Never zero; period 2^W-1.
- Arithmetic:
  - Ones counter is LEN_LOG+1 bits and cannot overflow (max L).
  - Run counter is wide enough for WARM+L-1.
  - Operand 0 gives core_in always 0. Operand all-ones gives core_in=0 only when lfsr_a is all-ones.
- req_ready is never asserted outside IDLE.
- Requesters hold req_valid/req_data until accepted; the bench asserts this.
- resp_ready held high: DONE lasts 1 cycle.
- At most one job in flight; no queueing.

Decomposition:
- Package gsqrt_sched_pkg:
  - State enum typedef (IDLE, INIT, RUN, DONE).
  - LFSR tap-mask constant function indexed by W (W=3..12).
  - clog2 helper.
- Sub-module lfsr_gen (W, SEED; ports clk, rst, load, en, out), instantiated twice.
- Round-robin arbiter stays inline.

Test Plan:
- Single requester 0, operand 16 (0.25), resp_ready=1: accept at T, resp_valid exactly at T+274, resp_id=0. resp_data matches a cycle-exact golden core+LFSR model, and lies within 128±32 (sqrt 0.25 ≈ 0.5 of 256).
- Operand 0 and operand 63: core_in observed constant 0 for the whole RUN; for 63, core_in=0 on exactly the cycles where lfsr_a=63. resp_data equals the golden model.
- All 4 requesters valid at once, pointer=0: grants in order 0,1,2,3. Each req_ready is a single-cycle pulse; responses arrive in the same order with matching ids.
- Back-pressure: hold resp_ready=0 for 50 cycles in DONE. resp_valid, id and data stay stable; no new req_ready is issued; accept occurs the cycle after the handshake.
- Assert rst at RUN cycle 100: all outputs go to reset values immediately, no response is emitted, and a subsequent request completes normally with the golden result.
- core_rst_n check: low in IDLE/INIT/DONE, high for exactly WARM+L=272 cycles per job, and glitch-free since it is a flop output.
